// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port RAM with a shared tri-state data bus.
// Write acks 2 cycles after acceptance, read 3; requests are held off simply by staying busy.
module mem_arbiter #(
  parameter int ADDRESS_BUS_WIDTH = 13,
  parameter int DATA_BUS_WIDTH    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         f_req,
  input  logic [ADDRESS_BUS_WIDTH-1:0] f_addr,
  output logic                         f_ack,
  output logic [DATA_BUS_WIDTH-1:0]    f_rdata,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDRESS_BUS_WIDTH-1:0] d_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    d_wdata,
  output logic                         d_ack,
  output logic [DATA_BUS_WIDTH-1:0]    d_rdata,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
  inout  wire  [DATA_BUS_WIDTH-1:0]    mem_data,
  output logic                         mem_read_not_write,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  state_t                        state;
  state_t                        state_nxt;
  logic                          grant_d;
  logic                          accept;
  logic                          req_port;
  logic                          req_we;
  logic [ADDRESS_BUS_WIDTH-1:0]  req_addr;
  logic [DATA_BUS_WIDTH-1:0]     req_wdata;
  logic                          last_data;
  logic [DATA_BUS_WIDTH-1:0]     f_rdata_q;
  logic [DATA_BUS_WIDTH-1:0]     d_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_port  <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      last_data <= 1'b1;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      // Transaction is frozen at acceptance; later input changes are ignored.
      if (accept) begin
        req_port  <= grant_d;
        last_data <= grant_d;
        req_we    <= grant_d && d_we;
        req_addr  <= grant_d ? d_addr : f_addr;
        req_wdata <= d_wdata;
      end
      if (state == WAIT) begin
        if (req_port) d_rdata_q <= mem_data;
        else          f_rdata_q <= mem_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    // Round-robin: on contention the port not granted last time wins.
    grant_d   = d_req && (!f_req || !last_data);
    case (state)
      IDLE: begin
        if (f_req || d_req) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = req_we ? ACK : WAIT;
      WAIT:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_read_not_write = !((state == ACCESS) && req_we);
  assign mem_address        = (state == IDLE) ? '0 : req_addr;
  assign mem_data           = mem_read_not_write ? {DATA_BUS_WIDTH{1'bz}} : req_wdata;
  assign busy               = (state != IDLE);
  assign f_ack              = (state == ACK) && !req_port;
  assign d_ack              = (state == ACK) && req_port;
  assign f_rdata            = f_rdata_q;
  assign d_rdata            = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRESS_BUS_WIDTH, default 13, width of all word addresses.
REQ-002 Parameter DATA_BUS_WIDTH, default 32, width of all data paths.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock for all state; reset input 1, synchronous active-high reset.
REQ-004 f_req  input  1  fetch-port read request, held high until f_ack.
REQ-005 f_addr  input  ADDRESS_BUS_WIDTH  fetch word address.
REQ-006 f_ack  output  1  one-cycle pulse; f_rdata valid in same cycle.
REQ-007 f_rdata  output  DATA_BUS_WIDTH  fetch read data, held until next fetch completes.
REQ-008 d_req  input  1  data-port request, held high until d_ack.
REQ-009 d_we  input  1  data-port write enable (1 write, 0 read).
REQ-010 d_addr  input  ADDRESS_BUS_WIDTH  data word address.
REQ-011 d_wdata  input  DATA_BUS_WIDTH  data-port write data.
REQ-012 d_ack  output  1  one-cycle completion pulse.
REQ-013 d_rdata  output  DATA_BUS_WIDTH  data-port read data, held until next data read completes.
REQ-014 mem_address  output  ADDRESS_BUS_WIDTH  RAM address.
REQ-015 mem_data  inout  DATA_BUS_WIDTH  RAM bidirectional data bus.
REQ-016 mem_read_not_write  output  1  RAM direction: 1 read, 0 write.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 RAM timing contract: write committed on rising clk while mem_read_not_write=0; read data valid on mem_data by the end of the cycle after the address is presented.
REQ-019 mem_data SHALL be driven only while mem_read_not_write=0, otherwise high-impedance.
REQ-020 FSM states: IDLE, ACCESS, WAIT, ACK.
REQ-021 IDLE: if f_req or d_req high, select winner, latch its address, write data and direction (fetch is always read), go ACCESS; else stay IDLE with mem_address=0.
REQ-022 ACCESS: present latched address; for a write drive mem_read_not_write=0 and latched data, go ACK; for a read mem_read_not_write=1, go WAIT.
REQ-023 WAIT: hold address, mem_read_not_write=1; at end of cycle capture mem_data into winner's rdata register; go ACK.
REQ-024 ACK: pulse winner's ack for exactly one cycle, mem_read_not_write=1, go IDLE.
REQ-025 Latency from request sampled in IDLE to ack: write 2 cycles, read 3 cycles; minimum request-to-request spacing 3 (write) / 4 (read) cycles.
REQ-026 Arbitration: single requester wins; both high, the port not granted last wins (round-robin); after reset fetch port has priority.
REQ-027 Request inputs changing after acceptance SHALL NOT affect the in-flight transaction.
REQ-028 Requester deasserting req before ack: transaction still completes and ack still pulses.
REQ-029 Non-winner's rdata and ack SHALL remain unchanged during another port's transaction.
REQ-030 Addresses are full-width; all values including 2^ADDRESS_BUS_WIDTH-1 are legal, no wrap or clipping.

Reset
REQ-031 With reset high at a rising edge: state=IDLE, f_ack=0, d_ack=0, f_rdata=0, d_rdata=0, mem_address=0, mem_read_not_write=1, mem_data released, busy=0, priority to fetch.
REQ-032 Reset during any state SHALL abort the transaction with no ack; a write in ACCESS is not guaranteed committed.
REQ-033 Requests high during reset SHALL be sampled in the first IDLE cycle after reset release.

Verification
REQ-034 Data write d_addr=0x1FFF, d_wdata=0x0000FF03 -> mem_read_not_write=0 one cycle with 0x0000FF03 on mem_data, d_ack 2 cycles after acceptance.
REQ-035 Fetch read f_addr=0x1FFF after REQ-034 -> f_ack 3 cycles after acceptance, f_rdata=0x0000FF03, mem_data high-Z throughout.
REQ-036 f_req and d_req (read 0x0010) high together after reset -> fetch served first, then data; data ack arrives 4 cycles after fetch ack.
REQ-037 Both held high continuously for 4 transactions -> grants alternate F,D,F,D; no ack overlaps.
REQ-038 Reset asserted in WAIT of a fetch -> no f_ack, f_rdata=0, busy=0, mem_read_not_write=1 next cycle.
REQ-039 Data write 0x1234 to 0x0005 then data read 0x0005 -> d_rdata=0x00001234; f_rdata unchanged.
